dram_fifo_ctrl: RTL and testbench

Synchronous FIFO controller that sequences an external simple-dual-port distributed RAM (synchronous write, asynchronous read) into a first-word-fall-through (FWFT) stream buffer. It owns the read and write pointers, full/empty tracking, the valid/ready handshakes on both sides, and a synchronous flush. It sits between a producer and a consumer stream, with the RAM instance placed beside it at the parent level.

---
 rtl/dram_fifo_ctrl_if.sv | 51 +++++
 rtl/dram_fifo_ctrl.sv | 134 +++++++++++++
 tb/tb_dram_fifo_ctrl.sv | 264 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/dram_fifo_ctrl_if.sv
// -----------------------------------------------------------------------------
// dram_fifo_ctrl_if
//
// Purpose: bundles the producer-side and consumer-side stream handshakes of
// dram_fifo_ctrl into one interface.
//
// Handshake semantics (both streams): a word moves on a rising clock edge
// exactly when valid and ready are both 1 in the cycle before that edge.
// Once the source raises valid it holds valid and data stable until ready.
// The FIFO never drops m_valid except through a read, a flush or a reset.
//
// Signals:
//   s_valid  producer data valid
//   s_ready  FIFO can accept a word
//   s_data   producer data word
//   m_valid  head word available
//   m_ready  consumer accepts the head word
//   m_data   head word
//
// Modports:
//   master - the FIFO controller side (drives s_ready, m_valid, m_data)
//   slave  - the environment side (drives s_valid, s_data, m_ready)
// -----------------------------------------------------------------------------
interface dram_fifo_ctrl_if #(
    parameter int BIT_WIDTH = 32
);
    logic                 s_valid;
    logic                 s_ready;
    logic [BIT_WIDTH-1:0] s_data;
    logic                 m_valid;
    logic                 m_ready;
    logic [BIT_WIDTH-1:0] m_data;

    modport master (
        input  s_valid,
        input  s_data,
        input  m_ready,
        output s_ready,
        output m_valid,
        output m_data
    );

    modport slave (
        output s_valid,
        output s_data,
        output m_ready,
        input  s_ready,
        input  m_valid,
        input  m_data
    );
endinterface

// File: rtl/dram_fifo_ctrl.sv
// -----------------------------------------------------------------------------
// dram_fifo_ctrl
//
// Purpose: controller for a first-word-fall-through FIFO built around an
// external simple-dual-port distributed RAM (synchronous write, asynchronous
// read). The controller owns the read/write pointers, full/empty decode, both
// stream handshakes and a single-cycle synchronous flush. The RAM sits beside
// this block at the parent level.
//
// Optional feature macro: FIFO_LEVEL_EN
//   defined   -> adds the 'level' occupancy output (wr_ptr - rd_ptr)
//   undefined -> no level port and no subtractor; all else identical
//
// Parameters:
//   FIFO_SIZE  number of RAM entries (power of two, >= 2)
//   BIT_WIDTH  data width
//
// Ports:
//   clk        clock, all logic on the rising edge
//   rst        synchronous active-high reset (priority over clr)
//   clr        synchronous flush, empties the FIFO in one cycle
//   bus        stream interface (master modport): s_valid/s_ready/s_data,
//              m_valid/m_ready/m_data
//   full       FIFO holds FIFO_SIZE words
//   empty      FIFO holds no words
//   ram_we     RAM write enable
//   ram_waddr  RAM write address (MSB always 0)
//   ram_raddr  RAM read address (MSB always 0)
//   ram_din    RAM write data (= s_data)
//   ram_dout   RAM asynchronous read data
//   level      occupancy 0..FIFO_SIZE (FIFO_LEVEL_EN only)
// -----------------------------------------------------------------------------
module dram_fifo_ctrl #(
    parameter int FIFO_SIZE = 16,
    parameter int BIT_WIDTH = 32,
    localparam int AW       = $clog2(FIFO_SIZE)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clr,
    dram_fifo_ctrl_if.master     bus,
    output logic                 full,
    output logic                 empty,
    output logic                 ram_we,
    output logic [AW:0]          ram_waddr,
    output logic [AW:0]          ram_raddr,
    output logic [BIT_WIDTH-1:0] ram_din,
    input  logic [BIT_WIDTH-1:0] ram_dout
`ifdef FIFO_LEVEL_EN
    ,
    output logic [AW:0]          level
`endif
);

    localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

    // Pointers carry one extra wrap bit so that "same index, different lap"
    // distinguishes full from empty without a separate counter.
    logic [AW:0] wr_ptr_q;
    logic [AW:0] wr_ptr_d;
    logic [AW:0] rd_ptr_q;
    logic [AW:0] rd_ptr_d;

    logic ptr_eq;
    logic full_raw;
    logic wr_fire;
    logic rd_fire;

    // -------------------------------------------------------------------------
    // Flag decode from registered pointers only.
    // While rst is high the flags are forced to their reset values, so a
    // mid-operation reset shows empty/not-full immediately rather than after
    // the pointers clear on the edge.
    // -------------------------------------------------------------------------
    assign ptr_eq   = (wr_ptr_q == rd_ptr_q);
    assign full_raw = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                      (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

    assign empty = rst || ptr_eq;
    assign full  = !rst && full_raw;

    assign bus.s_ready = !full_raw && !rst;
    assign bus.m_valid = !ptr_eq && !rst;

    // Flush wins over both handshakes in its cycle.
    assign wr_fire = bus.s_valid && bus.s_ready && !clr;
    assign rd_fire = bus.m_valid && bus.m_ready && !clr;

    // -------------------------------------------------------------------------
    // RAM side. The read port is asynchronous, so the head word is simply the
    // RAM output at the current read index (first-word-fall-through).
    // -------------------------------------------------------------------------
    assign ram_we     = wr_fire;
    assign ram_waddr  = {1'b0, wr_ptr_q[AW-1:0]};
    assign ram_raddr  = {1'b0, rd_ptr_q[AW-1:0]};
    assign ram_din    = bus.s_data;
    assign bus.m_data = ram_dout;

`ifdef FIFO_LEVEL_EN
    // Modulo subtraction of the wrap-extended pointers yields 0..FIFO_SIZE.
    assign level = rst ? '0 : (wr_ptr_q - rd_ptr_q);
`endif

    // -------------------------------------------------------------------------
    // Next-state pointers.
    // A flush moves rd_ptr onto the current wr_ptr, which makes the FIFO
    // empty; RAM contents are left alone and become unreachable.
    // -------------------------------------------------------------------------
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (clr) begin
            rd_ptr_d = wr_ptr_q;
        end else begin
            if (wr_fire) begin
                wr_ptr_d = wr_ptr_q + PTR_ONE;
            end
            if (rd_fire) begin
                rd_ptr_d = rd_ptr_q + PTR_ONE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

endmodule

// File: tb/tb_dram_fifo_ctrl.sv
// -----------------------------------------------------------------------------
// tb_dram_fifo_ctrl
//
// Bench for dram_fifo_ctrl with FIFO_SIZE = 4, BIT_WIDTH = 8. A behavioural
// queue model tracks FIFO contents; a compare process checks every DUT output
// against it on each falling edge. Directed scenarios add literal checks.
// -----------------------------------------------------------------------------
module tb_dram_fifo_ctrl;

    localparam int FS = 4;
    localparam int BW = 8;
    localparam int AW = 2;

    // ---------------------------------------------------------------- clock/reset
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic clr = 1'b0;

    always #5 clk = ~clk;

    // ---------------------------------------------------------------- DUT
    dram_fifo_ctrl_if #(.BIT_WIDTH(BW)) bus ();

    logic          full;
    logic          empty;
    logic          ram_we;
    logic [AW:0]   ram_waddr;
    logic [AW:0]   ram_raddr;
    logic [BW-1:0] ram_din;
    logic [BW-1:0] ram_dout;
`ifdef FIFO_LEVEL_EN
    logic [AW:0]   level;
`endif

    dram_fifo_ctrl #(.FIFO_SIZE(FS), .BIT_WIDTH(BW)) dut (
        .clk       (clk),
        .rst       (rst),
        .clr       (clr),
        .bus       (bus),
        .full      (full),
        .empty     (empty),
        .ram_we    (ram_we),
        .ram_waddr (ram_waddr),
        .ram_raddr (ram_raddr),
        .ram_din   (ram_din),
        .ram_dout  (ram_dout)
`ifdef FIFO_LEVEL_EN
        ,
        .level     (level)
`endif
    );

    // Distributed RAM beside the controller: sync write, async read.
    logic [BW-1:0] mem [FS];
    initial for (int i = 0; i < FS; i++) mem[i] = '0;
    always @(posedge clk) if (ram_we) mem[ram_waddr[AW-1:0]] <= ram_din;
    assign ram_dout = mem[ram_raddr[AW-1:0]];

    // ---------------------------------------------------------------- counters
    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------------------------------------------------------- model
    // Contents of the FIFO as a plain queue, head at index 0.
    logic [BW-1:0] exp_q[$];
    bit            mdl_rd;
    bit            mdl_wr;

    always @(posedge clk) begin
        if (rst) begin
            exp_q.delete();
        end else if (clr) begin
            exp_q.delete();
        end else begin
            mdl_rd = (exp_q.size() > 0) && bus.m_ready;
            mdl_wr = bus.s_valid && (exp_q.size() < FS);
            if (mdl_rd) void'(exp_q.pop_front());
            if (mdl_wr) exp_q.push_back(bus.s_data);
        end
    end

    // Compare process: outputs settle well before the falling edge.
    always @(negedge clk) begin
        logic exp_empty;
        logic exp_full;
        logic exp_we;
        exp_empty = rst || (exp_q.size() == 0);
        exp_full  = !rst && (exp_q.size() == FS);
        exp_we    = !rst && !clr && bus.s_valid && (exp_q.size() < FS);
        chk("empty", 32'(empty), 32'(exp_empty));
        chk("full", 32'(full), 32'(exp_full));
        chk("s_ready", 32'(bus.s_ready), 32'(!exp_full && !rst));
        chk("m_valid", 32'(bus.m_valid), 32'(!exp_empty));
        chk("ram_we", 32'(ram_we), 32'(exp_we));
        chk("ram_din", 32'(ram_din), 32'(bus.s_data));
        chk("addr_msb", 32'({ram_waddr[AW], ram_raddr[AW]}), 32'(0));
        if (!exp_empty) chk("m_data", 32'(bus.m_data), 32'(exp_q[0]));
`ifdef FIFO_LEVEL_EN
        chk("level", 32'(level), rst ? 32'(0) : 32'(exp_q.size()));
`endif
    end

    // ---------------------------------------------------------------- drivers
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.s_valid = 1'b0;
        bus.m_ready = 1'b0;
        clr         = 1'b0;
    endtask

    task automatic write_word(input logic [BW-1:0] d);
        bus.s_valid = 1'b1;
        bus.s_data  = d;
        step();
        bus.s_valid = 1'b0;
    endtask

    // ---------------------------------------------------------------- stimulus
    logic [BW-1:0] got_q[$];

    initial begin
        bus.s_valid = 1'b0;
        bus.s_data  = '0;
        bus.m_ready = 1'b0;
        rst = 1'b1;
        step();
        chk("rst_s_ready", 32'(bus.s_ready), 32'(0));
        chk("rst_empty", 32'(empty), 32'(1));
        step();
        rst = 1'b0;
        #1;
        chk("post_rst_s_ready", 32'(bus.s_ready), 32'(1));
        chk("post_rst_m_valid", 32'(bus.m_valid), 32'(0));

        // Single word, one-cycle latency.
        write_word(8'hA1);
        chk("a1_m_valid", 32'(bus.m_valid), 32'(1));
        chk("a1_m_data", 32'(bus.m_data), 32'h0000_00A1);
        chk("a1_empty", 32'(empty), 32'(0));
`ifdef FIFO_LEVEL_EN
        chk("a1_level", 32'(level), 32'(1));
`endif
        bus.m_ready = 1'b1;
        step();
        idle();

        // Fill to full, blocked fifth write, drain in order.
        for (int i = 1; i <= 4; i++) write_word(BW'(i));
        chk("fill_full", 32'(full), 32'(1));
        chk("fill_s_ready", 32'(bus.s_ready), 32'(0));
        bus.s_valid = 1'b1;
        bus.s_data  = 8'h05;
        #1;
        chk("fifth_we", 32'(ram_we), 32'(0));
        step();
        chk("fifth_still_full", 32'(full), 32'(1));
        bus.s_valid = 1'b0;
        bus.m_ready = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            chk("drain_data", 32'(bus.m_data), 32'(i));
            step();
        end
        idle();
        chk("drain_empty", 32'(empty), 32'(1));

        // Continuous streaming, 20 cycles.
        got_q.delete();
        bus.s_valid = 1'b1;
        bus.m_ready = 1'b1;
        for (int k = 0; k < 20; k++) begin
            bus.s_data = BW'(8'h10 + k);
            #1;
            if (k == 0) chk("stream_fill", 32'(bus.m_valid), 32'(0));
            else begin
                chk("stream_empty", 32'(empty), 32'(0));
`ifdef FIFO_LEVEL_EN
                chk("stream_level", 32'(level), 32'(1));
`endif
            end
            if (bus.m_valid) got_q.push_back(bus.m_data);
            step();
        end
        bus.s_valid = 1'b0;
        chk("stream_last", 32'(bus.m_data), 32'h0000_0023);
        step();
        idle();
        chk("stream_count", 32'(got_q.size()), 32'(19));
        for (int k = 0; k < got_q.size(); k++)
            chk("stream_order", 32'(got_q[k]), 32'(8'h10 + k));

        // Full with simultaneous read and write: only the read occurs.
        for (int i = 0; i < 4; i++) write_word(BW'(8'hB0 + i));
        bus.s_valid = 1'b1;
        bus.s_data  = 8'hB4;
        bus.m_ready = 1'b1;
        step();
        idle();
        chk("full_rw_s_ready", 32'(bus.s_ready), 32'(1));
        chk("full_rw_head", 32'(bus.m_data), 32'h0000_00B1);
`ifdef FIFO_LEVEL_EN
        chk("full_rw_level", 32'(level), 32'(3));
`endif
        bus.m_ready = 1'b1;
        repeat (3) step();
        idle();

        // Flush with concurrent handshakes.
        for (int i = 0; i < 3; i++) write_word(BW'(8'hC0 + i));
        bus.s_valid = 1'b1;
        bus.s_data  = 8'hC3;
        bus.m_ready = 1'b1;
        clr = 1'b1;
        #1;
        chk("clr_we", 32'(ram_we), 32'(0));
        step();
        idle();
        chk("clr_empty", 32'(empty), 32'(1));
        chk("clr_m_valid", 32'(bus.m_valid), 32'(0));
`ifdef FIFO_LEVEL_EN
        chk("clr_level", 32'(level), 32'(0));
`endif
        write_word(8'h5A);
        chk("after_clr_data", 32'(bus.m_data), 32'h0000_005A);
        bus.m_ready = 1'b1;
        step();
        idle();

        // Reset mid-operation with handshakes active.
        write_word(8'hD0);
        write_word(8'hD1);
        bus.s_valid = 1'b1;
        bus.s_data  = 8'hD2;
        bus.m_ready = 1'b1;
        rst = 1'b1;
        step();
        rst = 1'b0;
        idle();
        #1;
        chk("mid_rst_empty", 32'(empty), 32'(1));
        chk("mid_rst_s_ready", 32'(bus.s_ready), 32'(1));
        chk("mid_rst_m_valid", 32'(bus.m_valid), 32'(0));
        bus.m_ready = 1'b1;
        step();
        chk("mid_rst_no_stale", 32'(bus.m_valid), 32'(0));
        idle();
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
